// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers used by the vector<->stream converters.
package axis_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } a2v_state_t;

  // Beat counter width; a single-beat vector still gets a 1-bit counter.
  function automatic int ctr_width(input int ctr_max);
    return (ctr_max == 0) ? 1 : $clog2(ctr_max + 1);
  endfunction

endpackage

// File: rtl/axis_to_vector_if.sv
// AXI-Stream handshake bundle without user/keep signals.
interface axis_to_vector_if #(
  parameter int DATA_W = 8
);
  logic              tready;
  logic              tvalid;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_to_vector.sv
// Collects a fixed-length AXI-Stream packet into one wide register and
// strobes vec_valid on completion; wrong-length packets raise len_err.
module axis_to_vector
  import axis_pkg::*;
#(
  parameter int VEC_BYTES  = 1,
  parameter int AXIS_BYTES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                   clk,
  input  logic                   sresetn,
  axis_to_vector_if.slave        axis,
  output logic [VEC_BYTES*8-1:0] vec,
  output logic                   vec_valid,
  output logic                   len_err
);

  localparam int SLICE_W   = AXIS_BYTES * 8;
  localparam int VEC_W     = VEC_BYTES * 8;
  localparam int CTR_MAX   = VEC_BYTES / AXIS_BYTES - 1;
  localparam int CTR_WIDTH = ctr_width(CTR_MAX);
  localparam logic [CTR_WIDTH-1:0] CTR_TOP  = CTR_WIDTH'(CTR_MAX);
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = (MSB_FIRST != 0) ? CTR_TOP : '0;
  localparam logic [CTR_WIDTH-1:0] CTR_LAST = (MSB_FIRST != 0) ? '0 : CTR_TOP;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  generate
    if (AXIS_BYTES < 1 || VEC_BYTES < AXIS_BYTES || (VEC_BYTES % AXIS_BYTES) != 0) begin : g_param_check
      $error("axis_to_vector: VEC_BYTES must be a non-zero multiple of AXIS_BYTES");
    end
  endgenerate

  a2v_state_t           state_q;
  logic [CTR_WIDTH-1:0] ctr_q;
  logic [CTR_WIDTH-1:0] ctr_d;
  logic [VEC_W-1:0]     acc_q;
  logic [VEC_W-1:0]     acc_d;
  logic [VEC_W-1:0]     vec_q;
  logic                 vec_valid_q;
  logic                 len_err_q;
  logic                 beat_acc;
  logic                 at_last;

  // Ready simply follows reset: the sink never stalls the stream.
  assign axis.tready = sresetn;
  assign beat_acc    = axis.tvalid && axis.tready;
  assign at_last     = (ctr_q == CTR_LAST);

  // acc_d is the shadow register with the current beat merged in, so the
  // final beat can be published in the same edge it is accepted.
  always_comb begin
    acc_d = acc_q;
    acc_d[int'(ctr_q)*SLICE_W +: SLICE_W] = axis.tdata;
    ctr_d = (MSB_FIRST != 0) ? (ctr_q - CTR_ONE) : (ctr_q + CTR_ONE);
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q     <= COLLECT;
      ctr_q       <= CTR_INIT;
      acc_q       <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      vec_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      if (beat_acc) begin
        case (state_q)
          COLLECT: begin
            if (at_last && axis.tlast) begin
              vec_q       <= acc_d;
              vec_valid_q <= 1'b1;
              ctr_q       <= CTR_INIT;
            end else if (axis.tlast) begin
              len_err_q <= 1'b1;
              ctr_q     <= CTR_INIT;
            end else if (at_last) begin
              // Too long: flag now, swallow the rest up to tlast.
              len_err_q <= 1'b1;
              ctr_q     <= CTR_INIT;
              state_q   <= DISCARD;
            end else begin
              acc_q <= acc_d;
              ctr_q <= ctr_d;
            end
          end
          DISCARD: begin
            if (axis.tlast) begin
              state_q <= COLLECT;
            end
          end
          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_axis_to_vector.sv
// Directed bench for axis_to_vector: LSB-first 4x1, MSB-first 4x1 and 4x4 instances.
module tb_axis_to_vector;

  logic clk;
  logic sresetn;

  axis_to_vector_if #(.DATA_W(8))  if0 ();
  axis_to_vector_if #(.DATA_W(8))  if1 ();
  axis_to_vector_if #(.DATA_W(32)) if2 ();

  logic [31:0] vec0, vec1, vec2;
  logic        vv0, vv1, vv2;
  logic        err0, err1, err2;

  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .sresetn(sresetn), .axis(if0), .vec(vec0), .vec_valid(vv0), .len_err(err0));
  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .sresetn(sresetn), .axis(if1), .vec(vec1), .vec_valid(vv1), .len_err(err1));
  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(4), .MSB_FIRST(0)) dut2 (
    .clk(clk), .sresetn(sresetn), .axis(if2), .vec(vec2), .vec_valid(vv2), .len_err(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    bit          valid;
    logic [31:0] data;
    bit          last;
    bit          exp_vv;
    bit          exp_err;
    logic [31:0] exp_vec;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(int dut, bit valid, logic [31:0] data, bit last,
                     bit exp_vv, bit exp_err, logic [31:0] exp_vec);
    vec_t v;
    v.dut = dut; v.valid = valid; v.data = data; v.last = last;
    v.exp_vv = exp_vv; v.exp_err = exp_err; v.exp_vec = exp_vec;
    tbl.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int dut, bit valid, logic [31:0] data, bit last);
    if0.tvalid = 1'b0; if1.tvalid = 1'b0; if2.tvalid = 1'b0;
    if0.tlast  = 1'b0; if1.tlast  = 1'b0; if2.tlast  = 1'b0;
    case (dut)
      0: begin if0.tvalid = valid; if0.tdata = data[7:0]; if0.tlast = last; end
      1: begin if1.tvalid = valid; if1.tdata = data[7:0]; if1.tlast = last; end
      default: begin if2.tvalid = valid; if2.tdata = data; if2.tlast = last; end
    endcase
  endtask

  function automatic logic [31:0] vec_of(int dut);
    return (dut == 0) ? vec0 : (dut == 1) ? vec1 : vec2;
  endfunction
  function automatic logic vv_of(int dut);
    return (dut == 0) ? vv0 : (dut == 1) ? vv1 : vv2;
  endfunction
  function automatic logic err_of(int dut);
    return (dut == 0) ? err0 : (dut == 1) ? err1 : err2;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev_vec;
    logic [7:0]  pkt [4];
    bit          v;

    sresetn = 1'b0;
    if0.tdata = '0; if1.tdata = '0; if2.tdata = '0;
    drive(0, 1'b0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst.tready0", {31'b0, if0.tready}, 32'h0);
    check("rst.tready2", {31'b0, if2.tready}, 32'h0);
    check("rst.vec0", vec0, 32'h0);
    check("rst.vec1", vec1, 32'h0);
    check("rst.vec2", vec2, 32'h0);
    check("rst.strobes", {29'b0, vv0, err0, vv2}, 32'h0);

    @(negedge clk);
    sresetn = 1'b1;
    #1;
    check("run.tready0", {31'b0, if0.tready}, 32'h1);

    // LSB-first: good, idle, short, good, long, good
    add(0, 1, 32'h11, 0, 0, 0, 32'h0);
    add(0, 1, 32'h22, 0, 0, 0, 32'h0);
    add(0, 1, 32'h33, 0, 0, 0, 32'h0);
    add(0, 1, 32'h44, 1, 1, 0, 32'h44332211);
    add(0, 0, 32'h00, 0, 0, 0, 32'h44332211);
    add(0, 1, 32'hAA, 0, 0, 0, 32'h44332211);
    add(0, 1, 32'hBB, 1, 0, 1, 32'h44332211);
    add(0, 1, 32'h01, 0, 0, 0, 32'h44332211);
    add(0, 1, 32'h02, 0, 0, 0, 32'h44332211);
    add(0, 1, 32'h03, 0, 0, 0, 32'h44332211);
    add(0, 1, 32'h04, 1, 1, 0, 32'h04030201);
    add(0, 1, 32'h10, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h20, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h30, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h40, 0, 0, 1, 32'h04030201);
    add(0, 1, 32'h50, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h60, 1, 0, 0, 32'h04030201);
    add(0, 1, 32'h05, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h06, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h07, 0, 0, 0, 32'h04030201);
    add(0, 1, 32'h08, 1, 1, 0, 32'h08070605);
    // MSB-first, two packets back to back
    add(1, 1, 32'h11, 0, 0, 0, 32'h0);
    add(1, 1, 32'h22, 0, 0, 0, 32'h0);
    add(1, 1, 32'h33, 0, 0, 0, 32'h0);
    add(1, 1, 32'h44, 1, 1, 0, 32'h11223344);
    add(1, 1, 32'hAA, 0, 0, 0, 32'h11223344);
    add(1, 1, 32'hBB, 0, 0, 0, 32'h11223344);
    add(1, 1, 32'hCC, 0, 0, 0, 32'h11223344);
    add(1, 1, 32'hDD, 1, 1, 0, 32'hAABBCCDD);
    // Single-beat vectors, then a long packet discarded up to its tlast
    add(2, 1, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF);
    add(2, 1, 32'h01020304, 1, 1, 0, 32'h01020304);
    add(2, 1, 32'h00000055, 0, 0, 1, 32'h01020304);
    add(2, 1, 32'h00000066, 0, 0, 0, 32'h01020304);
    add(2, 1, 32'h00000077, 1, 0, 0, 32'h01020304);
    add(2, 1, 32'h00000088, 1, 1, 0, 32'h00000088);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].dut, tbl[i].valid, tbl[i].data, tbl[i].last);
      @(posedge clk);
      #1;
      $display("vector %0d dut%0d valid=%b data=%h last=%b -> vec=%h vv=%b err=%b",
               i, tbl[i].dut, tbl[i].valid, tbl[i].data, tbl[i].last,
               vec_of(tbl[i].dut), vv_of(tbl[i].dut), err_of(tbl[i].dut));
      check($sformatf("v%0d.vec_valid", i), {31'b0, vv_of(tbl[i].dut)}, {31'b0, tbl[i].exp_vv});
      check($sformatf("v%0d.len_err", i), {31'b0, err_of(tbl[i].dut)}, {31'b0, tbl[i].exp_err});
      check($sformatf("v%0d.vec", i), vec_of(tbl[i].dut), tbl[i].exp_vec);
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);

    // Random tvalid gaps across one good packet on the LSB-first instance
    pkt[0] = 8'hC1; pkt[1] = 8'hC2; pkt[2] = 8'hC3; pkt[3] = 8'hC4;
    prev_vec = 32'h08070605;
    for (int b = 0; b < 4; b++) begin
      v = 1'b0;
      for (int g = 0; g < 16 && !v; g++) begin
        @(negedge clk);
        v = (g >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        drive(0, v, {24'h0, pkt[b]}, b == 3);
        @(posedge clk);
        #1;
        $display("gap beat %0d valid=%b data=%h -> vec=%h vv=%b", b, v, pkt[b], vec0, vv0);
        if (!(v && b == 3)) begin
          check($sformatf("gap%0d.%0d.vec_valid", b, g), {31'b0, vv0}, 32'h0);
          check($sformatf("gap%0d.%0d.vec_hold", b, g), vec0, prev_vec);
        end
      end
    end
    check("gap.final_vv", {31'b0, vv0}, 32'h1);
    check("gap.final_vec", vec0, 32'hC4C3C2C1);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("gap.strobe_one_cycle", {31'b0, vv0}, 32'h0);
    check("gap.vec_stable", vec0, 32'hC4C3C2C1);

    // Reset mid-packet: vec clears at once, partial packet is forgotten
    @(negedge clk);
    drive(0, 1'b1, 32'hE1, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'hE2, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'h0, 1'b0);
    #2;
    sresetn = 1'b0;
    #1;
    $display("async reset -> vec0=%h tready0=%b", vec0, if0.tready);
    check("arst.vec0", vec0, 32'h0);
    check("arst.tready0", {31'b0, if0.tready}, 32'h0);
    @(negedge clk);
    sresetn = 1'b1;
    pkt[0] = 8'hF1; pkt[1] = 8'hF2; pkt[2] = 8'hF3; pkt[3] = 8'hF4;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      drive(0, 1'b1, {24'h0, pkt[b]}, b == 3);
      @(posedge clk);
      #1;
      $display("post-reset beat %0d data=%h -> vec=%h vv=%b err=%b", b, pkt[b], vec0, vv0, err0);
      check($sformatf("prst%0d.vec_valid", b), {31'b0, vv0}, (b == 3) ? 32'h1 : 32'h0);
      check($sformatf("prst%0d.len_err", b), {31'b0, err0}, 32'h0);
      check($sformatf("prst%0d.vec", b), vec0, (b == 3) ? 32'hF4F3F2F1 : 32'h0);
    end
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_to_vector.md
# axis_to_vector

Receive-side counterpart of the vector-to-stream serialiser. It collects a fixed-length AXI-Stream packet of `VEC_BYTES/AXIS_BYTES` beats and assembles it into one `VEC_BYTES`-wide register. It publishes the result with a single-cycle valid strobe. It sits at stream sinks that need a whole header, config word or status word in parallel, and it flags and discards packets of the wrong length.

## Interface
- `VEC_BYTES`, default 1: width of the assembled vector, in bytes. Must be a multiple of `AXIS_BYTES`.
- `AXIS_BYTES`, default 1: stream data width, in bytes.
- `MSB_FIRST`, default 0: beat order.
  - 0: the first beat fills slice 0 (`vec[AXIS_BYTES*8-1:0]`).
  - 1: the first beat fills the top slice.
- `clk`  in  1  sole clock.
- `sresetn`  in  1  reset; asynchronous and active-low.
- `axis_tready`  out  1  slave ready.
- `axis_tvalid`  in  1  slave valid.
- `axis_tlast`  in  1  end of packet.
- `axis_tdata`  in  `AXIS_BYTES*8`  beat data.
- `vec`  out  `VEC_BYTES*8`  last complete vector; registered and held until the next completion.
- `vec_valid`  out  1  one-cycle strobe: `vec` was updated this cycle.
- `len_err`  out  1  one-cycle strobe: a wrong-length packet was detected.

## Operation
- Constants:
  - `CTR_MAX = VEC_BYTES/AXIS_BYTES - 1`.
  - `CTR_WIDTH = (CTR_MAX==0) ? 1 : $clog2(CTR_MAX+1)`.
  - `CTR_INIT = MSB_FIRST ? CTR_MAX : 0`.
  - `CTR_LAST = MSB_FIRST ? 0 : CTR_MAX`.
- A beat is accepted when `axis_tvalid && axis_tready`.
- `axis_tready = sresetn`. The block never back-pressures outside reset.
- Shadow register `acc` (`VEC_BYTES*8`): each accepted beat in state COLLECT writes slice `ctr`, i.e. bits `[(ctr+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]`. `vec` does not change during partial reception.
- `ctr` steps toward `CTR_LAST` on each accepted beat: +1 when `MSB_FIRST=0`, −1 when `MSB_FIRST=1`.
- State machine: COLLECT, DISCARD. Reset state is COLLECT. The following rules apply only on an accepted beat:
  - COLLECT, `ctr==CTR_LAST`, `tlast=1`: good packet.
    - `vec <= acc` with the current beat merged into slice `ctr`.
    - `vec_valid` pulses.
    - `ctr <= CTR_INIT`; stay in COLLECT.
  - COLLECT, `ctr!=CTR_LAST`, `tlast=1`: short packet.
    - `len_err` pulses; `vec` is unchanged.
    - `ctr <= CTR_INIT`; stay in COLLECT.
  - COLLECT, `ctr==CTR_LAST`, `tlast=0`: long packet.
    - `len_err` pulses; `vec` is unchanged.
    - `ctr <= CTR_INIT`; go to DISCARD.
  - COLLECT, otherwise: store the beat and advance `ctr`.
  - DISCARD, `tlast=1`: go to COLLECT. No strobes.
  - DISCARD, `tlast=0`: drop the beat.
- Single-beat case (`CTR_MAX=0`): every packet must be exactly one beat. A beat with `tlast=1` completes a vector; a beat with `tlast=0` raises `len_err` and enters DISCARD.
- Cycles without an accepted beat leave all state untouched and hold both strobes at 0.

## Timing
- Reset values:
  - `vec = 0`, `vec_valid = 0`, `len_err = 0`, `axis_tready = 0`.
  - `ctr = CTR_INIT`, `acc = 0`, state COLLECT.
- Reset asserted mid-packet: the partial packet is lost and `vec` clears to 0 immediately (asynchronous). After release, the next accepted beat is treated as the first beat of a packet.
- Latency: the final beat is accepted at edge N. `vec` and `vec_valid` are valid after edge N, and `vec_valid` is low again after edge N+1.
- `len_err` is registered and has the same one-cycle latency relative to the offending beat.
- Back-to-back packets with no idle cycles are sustained: one beat per clock, with a `vec_valid` strobe every `CTR_MAX+1` cycles.
- `vec_valid` and `len_err` are never high in the same cycle.

## Structure
- The following constants belong in the shared `axis_pkg`, so the serialiser can reuse them:
  - the state enum typedef `a2v_state_t` {COLLECT, DISCARD};
  - the counter-width helper function.
- No sub-module. The slice write uses an indexed part-select on `acc`, and the handshake uses the existing slave AXIS port macro without user signals.
- Parameter check: `VEC_BYTES % AXIS_BYTES == 0`, enforced by an elaboration-time assertion.

## Test plan
- `VEC_BYTES=4`, `AXIS_BYTES=1`, `MSB_FIRST=0`: beats 11, 22, 33, 44 (tlast on 44) → `vec=0x44332211`, `vec_valid` high for exactly 1 cycle after the last beat.
- Same stimulus with `MSB_FIRST=1` → `vec=0x11223344`. Then beats AA, BB, CC, DD sent back-to-back → second strobe exactly 4 cycles later with `vec=0xAABBCCDD`.
- Short packet AA, BB (tlast) → `len_err` pulse, `vec` keeps its prior value. A following good packet 01, 02, 03, 04 → `vec=0x04030201`.
- Long packet of 6 beats (tlast on the 6th) → `len_err` on the 4th beat, beats 5–6 dropped, no `vec_valid`. The next good packet decodes correctly.
- Random `tvalid` gaps (about 50 %) across a good packet → same `vec` as the gap-free run. `vec` is stable between strobes.
- Reset asserted after 2 beats, released, then a 4-beat packet sent → `vec` reads 0 during reset, and after release `vec` equals the new packet only.
- `VEC_BYTES=AXIS_BYTES=4`: single beats each with tlast → a strobe every cycle. One beat with `tlast=0` → `len_err`, and the beat after it is discarded up to and including the next tlast beat.
